// File: rtl/gpu_data_mem_banked_pkg.sv
// ============================================================================
// gpu_mem_pkg
// Shared types and helpers for the banked GPU data memory.
//   chan_state_e : per-channel request FSM states
//   LAT_CNT_W    : width of the per-channel latency down-counter
//   STAT_W       : width of the optional statistics counters
//   bank_of()    : bank index of an address (low address bits)
//   sat_add()    : saturating add for the statistics counters
// ============================================================================
package gpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } chan_state_e;

    // Latencies up to 2**LAT_CNT_W are representable.
    localparam int LAT_CNT_W = 8;
    localparam int STAT_W    = 32;

    // NUM_BANKS is a power of two, so the bank is simply the low address bits.
    function automatic int bank_of(input logic [31:0] addr, input int num_banks);
        return int'(addr & 32'(num_banks - 1));
    endfunction

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [STAT_W-1:0] b);
        logic [STAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/gpu_data_mem_banked_if.sv
// ============================================================================
// gpu_data_mem_banked_if
// Bundles the host preload port and the per-channel LSU read/write
// valid/ready buses of the banked data memory.
//   master : host / LSU side (drives requests, receives ready and data)
//   slave  : memory side
// ============================================================================
interface gpu_data_mem_banked_if #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4
);
    logic                                      load_en;
    logic [ADDR_BITS-1:0]                      load_addr;
    logic [DATA_BITS-1:0]                      load_data;

    logic [NUM_CHANNELS-1:0]                   read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    read_address;
    logic [NUM_CHANNELS-1:0]                   read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    read_data;

    logic [NUM_CHANNELS-1:0]                   write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    write_data;
    logic [NUM_CHANNELS-1:0]                   write_ready;

    modport master (
        output load_en, load_addr, load_data,
        output read_valid, read_address,
        output write_valid, write_address, write_data,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  load_en, load_addr, load_data,
        input  read_valid, read_address,
        input  write_valid, write_address, write_data,
        output read_ready, read_data, write_ready
    );

endinterface

// File: rtl/gpu_data_mem_banked_rr_arbiter.sv
// ============================================================================
// rr_arbiter
// Combinational round-robin arbiter for one memory bank.
//   i_req    : per-channel request vector
//   i_ptr    : channel with highest priority this cycle
//   o_grant  : one-hot grant (all zero when no request)
//   o_winner : index of the granted channel
//   o_any    : a grant was issued
// ============================================================================
module rr_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int PTR_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic [NUM_CHANNELS-1:0] i_req,
    input  logic [PTR_W-1:0]        i_ptr,
    output logic [NUM_CHANNELS-1:0] o_grant,
    output logic [PTR_W-1:0]        o_winner,
    output logic                    o_any
);

    int               w_sum;
    logic [PTR_W-1:0] w_idx;

    // Scan channels starting at the pointer; the first requester wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
        o_grant  = '0;
        o_winner = '0;
        o_any    = 1'b0;
        w_sum    = 0;
        w_idx    = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_sum = int'(i_ptr) + i;
            w_idx = PTR_W'(w_sum % NUM_CHANNELS);
            if (!o_any && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_winner       = w_idx;
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_data_mem_banked.sv
// ============================================================================
// gpu_data_mem_banked
// Multi-channel banked data memory with per-bank round-robin arbitration,
// configurable read/write latency and a host preload port.
//   clk    : system clock, all logic on posedge
//   reset  : synchronous, active-high; clears FSMs, pointers and outputs,
//            leaves the memory array untouched
//   bus    : gpu_data_mem_banked_if.slave (preload + per-channel read/write)
// Optional build macro GPU_DATA_MEM_STATS_EN adds saturating counters:
//   stat_reads / stat_writes : accepted reads / writes
//   stat_conflicts           : cycles where an idle requester was denied
// ============================================================================
module gpu_data_mem_banked
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int NUM_BANKS     = 2,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    gpu_data_mem_banked_if.slave  bus
`ifdef GPU_DATA_MEM_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_reads,
    output logic [STAT_W-1:0]     stat_writes,
    output logic [STAT_W-1:0]     stat_conflicts
`endif
);

    localparam int PTR_W     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [LAT_CNT_W-1:0] RD_CNT_INIT = LAT_CNT_W'(READ_LATENCY - 1);
    localparam logic [LAT_CNT_W-1:0] WR_CNT_INIT = LAT_CNT_W'(WRITE_LATENCY - 1);

    if (READ_LATENCY < 1 || WRITE_LATENCY < 1) begin : g_bad_latency
        $error("gpu_data_mem_banked: latencies must be >= 1");
    end
    if (NUM_BANKS < 1 || NUM_BANKS > NUM_CHANNELS || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
        $error("gpu_data_mem_banked: NUM_BANKS must be a power of two in 1..NUM_CHANNELS");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem       [2**ADDR_BITS];
    chan_state_e          r_state     [NUM_CHANNELS];
    logic [LAT_CNT_W-1:0] r_cnt       [NUM_CHANNELS];
    logic                 r_is_write  [NUM_CHANNELS];
    logic [DATA_BITS-1:0] r_hold      [NUM_CHANNELS];
    logic [DATA_BITS-1:0] r_read_data [NUM_CHANNELS];
    logic [PTR_W-1:0]     r_ptr       [NUM_BANKS];

    // ------------------------------------------------------------------------
    // Request decode and per-bank arbitration
    // ------------------------------------------------------------------------
    logic [NUM_CHANNELS-1:0] w_req_any;
    logic [ADDR_BITS-1:0]    w_addr     [NUM_CHANNELS];
    logic [BANK_BITS-1:0]    w_bank     [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] w_bank_req [NUM_BANKS];
    logic [NUM_CHANNELS-1:0] w_grant    [NUM_BANKS];
    logic [PTR_W-1:0]        w_winner   [NUM_BANKS];
    logic [PTR_W-1:0]        w_ptr_next [NUM_BANKS];
    logic                    w_bank_any [NUM_BANKS];
    logic [NUM_CHANNELS-1:0] w_accept;

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_req_any[c] = (r_state[c] == IDLE) && (bus.write_valid[c] || bus.read_valid[c]);
            // A pending write is served before a pending read on the same channel.
            w_addr[c]    = bus.write_valid[c] ? bus.write_address[c] : bus.read_address[c];
            w_bank[c]    = BANK_BITS'(bank_of(32'(w_addr[c]), NUM_BANKS));
        end
        // Preload and reset both suppress every new grant for the cycle.
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                w_bank_req[b][c] = w_req_any[c] && (w_bank[c] == BANK_BITS'(b))
                                   && !bus.load_en && !reset;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        rr_arbiter #(
            .NUM_CHANNELS (NUM_CHANNELS),
            .PTR_W        (PTR_W)
        ) u_arb (
            .i_req    (w_bank_req[b]),
            .i_ptr    (r_ptr[b]),
            .o_grant  (w_grant[b]),
            .o_winner (w_winner[b]),
            .o_any    (w_bank_any[b])
        );

        assign w_ptr_next[b] = (w_winner[b] == PTR_W'(NUM_CHANNELS - 1))
                               ? '0 : w_winner[b] + 1'b1;
    end

    always_comb begin
        w_accept = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_accept = w_accept | w_grant[b];
        end
    end

    // ------------------------------------------------------------------------
    // Channel FSM: next state
    // ------------------------------------------------------------------------
    chan_state_e          w_next_state [NUM_CHANNELS];
    logic [LAT_CNT_W-1:0] w_next_cnt   [NUM_CHANNELS];
    logic                 w_op_write   [NUM_CHANNELS];
    logic                 w_load_rd    [NUM_CHANNELS];

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_next_state[c] = r_state[c];
            w_next_cnt[c]   = r_cnt[c];
            w_op_write[c]   = w_accept[c] ? bus.write_valid[c] : r_is_write[c];
            unique case (r_state[c])
                IDLE: begin
                    if (w_accept[c]) begin
                        w_next_cnt[c] = bus.write_valid[c] ? WR_CNT_INIT : RD_CNT_INIT;
                        w_next_state[c] = (w_next_cnt[c] == '0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt[c] == LAT_CNT_W'(1)) begin
                        w_next_state[c] = RESP;
                    end else begin
                        w_next_cnt[c] = r_cnt[c] - 1'b1;
                    end
                end
                RESP:    w_next_state[c] = IDLE;
                default: w_next_state[c] = IDLE;
            endcase
            // read_data only changes when a read is about to complete.
            w_load_rd[c] = (w_next_state[c] == RESP) && (r_state[c] != RESP) && !w_op_write[c];
        end
    end

    // ------------------------------------------------------------------------
    // Channel FSM, holding registers and arbitration pointers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_state[c]     <= IDLE;
                r_cnt[c]       <= '0;
                r_is_write[c]  <= 1'b0;
                r_hold[c]      <= '0;
                r_read_data[c] <= '0;
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_ptr[b] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_state[c] <= w_next_state[c];
                r_cnt[c]   <= w_next_cnt[c];
                if (w_accept[c]) begin
                    r_is_write[c] <= bus.write_valid[c];
                    r_hold[c]     <= r_mem[bus.read_address[c]];
                end
                if (w_load_rd[c]) begin
                    r_read_data[c] <= w_accept[c] ? r_mem[bus.read_address[c]] : r_hold[c];
                end
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_bank_any[b]) begin
                    r_ptr[b] <= w_ptr_next[b];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memory array: preload port plus one write per granted bank
    // ------------------------------------------------------------------------
    // NOTE: the array has no reset; preloaded contents must survive reset and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (bus.load_en) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_accept[c] && bus.write_valid[c]) begin
                r_mem[bus.write_address[c]] <= bus.write_data[c];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (decoded from registered state only)
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_out
        assign bus.read_ready[c]  = (r_state[c] == RESP) && !r_is_write[c];
        assign bus.write_ready[c] = (r_state[c] == RESP) &&  r_is_write[c];
        assign bus.read_data[c]   = r_read_data[c];

`ifndef SYNTHESIS
        // The request must stay asserted while the channel waits out its latency.
        a_valid_held: assert property (@(posedge clk) disable iff (reset)
            (r_state[c] == WAIT) |-> (r_is_write[c] ? bus.write_valid[c] : bus.read_valid[c]));
`endif
    end

`ifdef GPU_DATA_MEM_STATS_EN
    logic [STAT_W-1:0] r_stat_reads;
    logic [STAT_W-1:0] r_stat_writes;
    logic [STAT_W-1:0] r_stat_conflicts;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_reads     <= '0;
            r_stat_writes    <= '0;
            r_stat_conflicts <= '0;
        end else begin
            r_stat_reads     <= sat_add(r_stat_reads,
                                        STAT_W'($countones(w_accept & ~bus.write_valid)));
            r_stat_writes    <= sat_add(r_stat_writes,
                                        STAT_W'($countones(w_accept & bus.write_valid)));
            r_stat_conflicts <= sat_add(r_stat_conflicts,
                                        STAT_W'(|(w_req_any & ~w_accept)));
        end
    end

    assign stat_reads     = r_stat_reads;
    assign stat_writes    = r_stat_writes;
    assign stat_conflicts = r_stat_conflicts;
`endif

endmodule

// File: tb/tb_gpu_data_mem_banked.sv
// ============================================================================
// tb_gpu_data_mem_banked
// Two instances: dut_a with unit latencies, dut_b with READ_LATENCY=3 and
// WRITE_LATENCY=2. Expected completions are queued when a request is driven
// and retired by a monitor when the matching ready pulse appears.
// ============================================================================
module tb_gpu_data_mem_banked;

    localparam int AB      = 8;
    localparam int DB      = 8;
    localparam int NC      = 4;
    localparam int TIMEOUT = 50;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;

    always #5 clk = ~clk;

    gpu_data_mem_banked_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) bus_a ();
    gpu_data_mem_banked_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) bus_b ();

`ifdef GPU_DATA_MEM_STATS_EN
    logic [31:0] st_a_rd, st_a_wr, st_a_cf, st_b_rd, st_b_wr, st_b_cf;
`endif

    gpu_data_mem_banked #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .NUM_BANKS(2),
        .READ_LATENCY(1), .WRITE_LATENCY(1)
    ) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a)
`ifdef GPU_DATA_MEM_STATS_EN
        , .stat_reads(st_a_rd), .stat_writes(st_a_wr), .stat_conflicts(st_a_cf)
`endif
    );

    gpu_data_mem_banked #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .NUM_BANKS(2),
        .READ_LATENCY(3), .WRITE_LATENCY(2)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
`ifdef GPU_DATA_MEM_STATS_EN
        , .stat_reads(st_b_rd), .stat_writes(st_b_wr), .stat_conflicts(st_b_cf)
`endif
    );

    // ------------------------------------------------------------------------
    // Checking and scoreboard
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         d;
        int         ch;
        bit         wr;
        logic [7:0] data;
    } sb_t;

    sb_t sbq[$];

    function automatic logic get_rr(input int d, input int c);
        return (d == 0) ? bus_a.read_ready[c] : bus_b.read_ready[c];
    endfunction

    function automatic logic get_wr(input int d, input int c);
        return (d == 0) ? bus_a.write_ready[c] : bus_b.write_ready[c];
    endfunction

    function automatic logic [7:0] get_rd(input int d, input int c);
        return (d == 0) ? bus_a.read_data[c] : bus_b.read_data[c];
    endfunction

    task automatic sb_retire(input int d, input int c, input bit wr, input logic [7:0] data);
        int idx;
        idx = -1;
        for (int i = 0; i < sbq.size(); i++) begin
            if (idx < 0 && sbq[i].d == d && sbq[i].ch == c && sbq[i].wr == wr) idx = i;
        end
        if (idx < 0) begin
            check($sformatf("unexpected_%s_ready_d%0d_ch%0d", wr ? "wr" : "rd", d, c), 32'd1, 32'd0);
        end else begin
            if (!wr) check($sformatf("rd_data_d%0d_ch%0d", d, c), 32'(data), 32'(sbq[idx].data));
            sbq.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NC; c++) begin
                if (get_rr(d, c)) sb_retire(d, c, 1'b0, get_rd(d, c));
                if (get_wr(d, c)) sb_retire(d, c, 1'b1, 8'h00);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Drivers (all called at negedge)
    // ------------------------------------------------------------------------
    task automatic drive_rd(input int d, input int c, input logic v, input logic [7:0] a);
        if (d == 0) begin
            bus_a.read_valid[c] = v; bus_a.read_address[c] = a;
        end else begin
            bus_b.read_valid[c] = v; bus_b.read_address[c] = a;
        end
    endtask

    task automatic drive_wr(input int d, input int c, input logic v,
                            input logic [7:0] a, input logic [7:0] data);
        if (d == 0) begin
            bus_a.write_valid[c] = v; bus_a.write_address[c] = a; bus_a.write_data[c] = data;
        end else begin
            bus_b.write_valid[c] = v; bus_b.write_address[c] = a; bus_b.write_data[c] = data;
        end
    endtask

    task automatic drive_load(input int d, input logic en, input logic [7:0] a, input logic [7:0] data);
        if (d == 0) begin
            bus_a.load_en = en; bus_a.load_addr = a; bus_a.load_data = data;
        end else begin
            bus_b.load_en = en; bus_b.load_addr = a; bus_b.load_data = data;
        end
    endtask

    task automatic preload(input int d, input logic [7:0] a, input logic [7:0] data);
        drive_load(d, 1'b1, a, data);
        @(negedge clk);
        drive_load(d, 1'b0, 8'h00, 8'h00);
    endtask

    // Issue a read, wait for its ready pulse and return the number of cycles
    // from request to the cycle the pulse is visible.
    task automatic do_read(input int d, input int c, input logic [7:0] a,
                           input logic [7:0] exp, output int lat);
        sbq.push_back('{d, c, 1'b0, exp});
        drive_rd(d, c, 1'b1, a);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!get_rr(d, c) && lat < TIMEOUT);
        if (!get_rr(d, c)) check($sformatf("rd_timeout_d%0d_ch%0d", d, c), 32'd0, 32'd1);
        drive_rd(d, c, 1'b0, a);
        @(negedge clk);
        check($sformatf("rd_pulse_width_d%0d_ch%0d", d, c), 32'(get_rr(d, c)), 32'd0);
    endtask

    task automatic do_write(input int d, input int c, input logic [7:0] a,
                            input logic [7:0] data, output int lat);
        sbq.push_back('{d, c, 1'b1, 8'h00});
        drive_wr(d, c, 1'b1, a, data);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!get_wr(d, c) && lat < TIMEOUT);
        if (!get_wr(d, c)) check($sformatf("wr_timeout_d%0d_ch%0d", d, c), 32'd0, 32'd1);
        drive_wr(d, c, 1'b0, a, data);
        @(negedge clk);
        check($sformatf("wr_pulse_width_d%0d_ch%0d", d, c), 32'(get_wr(d, c)), 32'd0);
    endtask

    task automatic check_outputs_zero(input int d, input string tag);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("%s_rr_ch%0d", tag, c), 32'(get_rr(d, c)), 32'd0);
            check($sformatf("%s_wr_ch%0d", tag, c), 32'(get_wr(d, c)), 32'd0);
            check($sformatf("%s_rd_ch%0d", tag, c), 32'(get_rd(d, c)), 32'd0);
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    int t[NC];
    int lat;

    initial begin
        bus_a.load_en = 1'b0; bus_a.load_addr = '0; bus_a.load_data = '0;
        bus_a.read_valid = '0; bus_a.read_address = '0;
        bus_a.write_valid = '0; bus_a.write_address = '0; bus_a.write_data = '0;
        bus_b.load_en = 1'b0; bus_b.load_addr = '0; bus_b.load_data = '0;
        bus_b.read_valid = '0; bus_b.read_address = '0;
        bus_b.write_valid = '0; bus_b.write_address = '0; bus_b.write_data = '0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (3) @(negedge clk);

        check_outputs_zero(0, "reset_a");
        check_outputs_zero(1, "reset_b");
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Preload: 0x00..0x07 = 0x30+addr, 0x10 = 0xAB, 0x20 = 0x11.
        for (int i = 0; i < 8; i++) preload(0, 8'(i), 8'(8'h30 + i));
        preload(0, 8'h10, 8'hAB);
        preload(0, 8'h20, 8'h11);

        // Basic read, unit latency, then read_data holds.
        do_read(0, 0, 8'h10, 8'hAB, lat);
        check("basic_read_latency", 32'(lat), 32'd1);
        repeat (2) @(negedge clk);
        check("read_data_holds", 32'(get_rd(0, 0)), 32'hAB);

        // Reset clears read_data and returns bank pointers to 0.
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        check("reset_clears_read_data", 32'(get_rd(0, 0)), 32'd0);

        // Bank conflict: four channels on bank 0, granted in order 0..3.
        fork
            do_read(0, 0, 8'h00, 8'h30, t[0]);
            do_read(0, 1, 8'h02, 8'h32, t[1]);
            do_read(0, 2, 8'h04, 8'h34, t[2]);
            do_read(0, 3, 8'h06, 8'h36, t[3]);
        join
        for (int c = 0; c < NC; c++) check($sformatf("conflict1_order_ch%0d", c), 32'(t[c]), 32'(c + 1));

        // Pointer wrapped back to 0: ch0 wins the next contention again.
        fork
            do_read(0, 0, 8'h06, 8'h36, t[0]);
            do_read(0, 1, 8'h04, 8'h34, t[1]);
            do_read(0, 2, 8'h02, 8'h32, t[2]);
            do_read(0, 3, 8'h00, 8'h30, t[3]);
        join
        for (int c = 0; c < NC; c++) check($sformatf("conflict2_order_ch%0d", c), 32'(t[c]), 32'(c + 1));

        // Parallel banks complete on the same cycle.
        fork
            do_read(0, 0, 8'h00, 8'h30, t[0]);
            do_read(0, 1, 8'h01, 8'h31, t[1]);
        join
        check("parallel_bank0_latency", 32'(t[0]), 32'd1);
        check("parallel_bank1_latency", 32'(t[1]), 32'd1);

        // Write on ch2 and read on ch3 of the same address: write goes first.
        fork
            do_write(0, 2, 8'h20, 8'h55, t[2]);
            do_read(0, 3, 8'h20, 8'h55, t[3]);
        join
        check("raw_write_latency", 32'(t[2]), 32'd1);
        check("raw_read_latency", 32'(t[3]), 32'd2);

        // Same channel requests write and read together: write, then read sees it.
        sbq.push_back('{0, 1, 1'b1, 8'h00});
        sbq.push_back('{0, 1, 1'b0, 8'h77});
        drive_wr(0, 1, 1'b1, 8'h22, 8'h77);
        drive_rd(0, 1, 1'b1, 8'h22);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!get_wr(0, 1) && lat < TIMEOUT);
        check("same_ch_write_latency", 32'(lat), 32'd1);
        drive_wr(0, 1, 1'b0, 8'h22, 8'h77);
        do begin
            @(negedge clk);
            lat++;
        end while (!get_rr(0, 1) && lat < TIMEOUT);
        check("same_ch_read_latency", 32'(lat), 32'd3);
        drive_rd(0, 1, 1'b0, 8'h22);
        @(negedge clk);

        // ---- dut_b: READ_LATENCY=3, WRITE_LATENCY=2 ----
        preload(1, 8'h05, 8'h5A);

        // Preload on the request cycle delays the grant by one cycle.
        drive_load(1, 1'b1, 8'h09, 8'h99);
        fork
            do_read(1, 0, 8'h05, 8'h5A, t[0]);
            begin
                @(negedge clk);
                drive_load(1, 1'b0, 8'h00, 8'h00);
            end
        join
        check("load_blocks_grant_latency", 32'(t[0]), 32'd4);

        do_read(1, 0, 8'h09, 8'h99, lat);
        check("lat3_read_latency", 32'(lat), 32'd3);

        do_write(1, 2, 8'h0B, 8'hC3, lat);
        check("lat2_write_latency", 32'(lat), 32'd2);
        do_read(1, 2, 8'h0B, 8'hC3, lat);
        check("lat3_read_after_write", 32'(lat), 32'd3);

        // Reset while ch1 sits in WAIT: the read is dropped without a pulse.
        drive_rd(1, 1, 1'b1, 8'h05);
        repeat (2) @(negedge clk);
        check("wait_no_ready_yet", 32'(get_rr(1, 1)), 32'd0);
        reset_b = 1'b1;
        drive_rd(1, 1, 1'b0, 8'h05);
        @(negedge clk);
        check_outputs_zero(1, "reset_in_wait");
        reset_b = 1'b0;
        repeat (5) @(negedge clk);
        do_read(1, 1, 8'h05, 8'h5A, lat);
        check("mem_kept_after_reset", 32'(lat), 32'd3);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
